// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, aligns/extends load data
// (including lwl/lwr partial writes) and offers the result to WB and the forwarding network.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [77:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [73:0] ms_to_ws_bus,
    output logic [41:0] ms_fwd_bus
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEST_W   = 5;
    localparam int unsigned WSTRB_W  = 4;
    localparam int unsigned LD_W     = 7;
    localparam logic        READY_GO = 1'b1;

    typedef struct packed {
        logic [LD_W-1:0]   ld_inst;      // {lw,lb,lbu,lh,lhu,lwl,lwr}
        logic              res_from_mem;
        logic              gr_we;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] pc;
    } es_bus_t;

    logic              ms_valid;
    es_bus_t           ms_bus_r;
    logic [DATA_W-1:0] rdata_buf;
    logic              rdata_held;

    logic [DATA_W-1:0]  eff_rdata;
    logic [1:0]         addr;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [DATA_W-1:0]  load_result;
    logic [WSTRB_W-1:0] load_wstrb;
    logic [DATA_W-1:0]  final_result;
    logic [WSTRB_W-1:0] rf_wstrb;

    assign ms_allowin     = !ms_valid || (READY_GO && ws_allowin);
    assign ms_to_ws_valid = ms_valid && READY_GO;

    // Stage register, valid bit and the stall buffer for load data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            ms_bus_r   <= '0;
            rdata_buf  <= '0;
            rdata_held <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                ms_bus_r <= es_bus_t'(es_to_ms_bus);
            end
            // Leaving the stage always drops the buffer, even if a new load arrives this cycle
            if (ms_allowin) begin
                rdata_held <= 1'b0;
            end else if (ms_valid && ms_bus_r.res_from_mem && !rdata_held && !ws_allowin) begin
                rdata_buf  <= data_sram_rdata;
                rdata_held <= 1'b1;
            end
        end
    end

    assign eff_rdata = rdata_held ? rdata_buf : data_sram_rdata;
    assign addr      = ms_bus_r.res[1:0];

    // Load alignment and partial-write strobes; unknown encodings fall back to lw
    always_comb begin
        byte_sel    = 8'h00;
        half_sel    = addr[1] ? eff_rdata[31:16] : eff_rdata[15:0];
        load_result = eff_rdata;
        load_wstrb  = 4'b1111;

        case (addr)
            2'd0:    byte_sel = eff_rdata[7:0];
            2'd1:    byte_sel = eff_rdata[15:8];
            2'd2:    byte_sel = eff_rdata[23:16];
            default: byte_sel = eff_rdata[31:24];
        endcase

        if (ms_bus_r.ld_inst[6]) begin
            load_result = eff_rdata;
        end else if (ms_bus_r.ld_inst[5]) begin
            load_result = {{24{byte_sel[7]}}, byte_sel};
        end else if (ms_bus_r.ld_inst[4]) begin
            load_result = {24'h000000, byte_sel};
        end else if (ms_bus_r.ld_inst[3]) begin
            load_result = {{16{half_sel[15]}}, half_sel};
        end else if (ms_bus_r.ld_inst[2]) begin
            load_result = {16'h0000, half_sel};
        end else if (ms_bus_r.ld_inst[1]) begin
            case (addr)
                2'd0:    begin load_result = {eff_rdata[7:0], 24'h000000};  load_wstrb = 4'b1000; end
                2'd1:    begin load_result = {eff_rdata[15:0], 16'h0000};   load_wstrb = 4'b1100; end
                2'd2:    begin load_result = {eff_rdata[23:0], 8'h00};      load_wstrb = 4'b1110; end
                default: begin load_result = eff_rdata;                     load_wstrb = 4'b1111; end
            endcase
        end else if (ms_bus_r.ld_inst[0]) begin
            case (addr)
                2'd0:    begin load_result = eff_rdata;                     load_wstrb = 4'b1111; end
                2'd1:    begin load_result = {8'h00, eff_rdata[31:8]};      load_wstrb = 4'b0111; end
                2'd2:    begin load_result = {16'h0000, eff_rdata[31:16]};  load_wstrb = 4'b0011; end
                default: begin load_result = {24'h000000, eff_rdata[31:24]}; load_wstrb = 4'b0001; end
            endcase
        end
    end

    assign final_result = ms_bus_r.res_from_mem ? load_result : ms_bus_r.res;

    always_comb begin
        rf_wstrb = 4'b0000;
        if (ms_bus_r.gr_we) begin
            rf_wstrb = ms_bus_r.res_from_mem ? load_wstrb : 4'b1111;
        end
    end

    assign ms_to_ws_bus = {rf_wstrb, ms_bus_r.gr_we, ms_bus_r.dest, final_result, ms_bus_r.pc};
    assign ms_fwd_bus   = {rf_wstrb, ms_valid && ms_bus_r.gr_we, ms_bus_r.dest, final_result};

endmodule
